bias_add_relu: RTL and testbench
================================

Name: bias_add_relu

Overview:
- Stage directly downstream of the per-layer bias streamer.
- Consumes that block's ap_fifo bias stream plus the convolution accumulator stream.
- Adds the per-output-channel bias, applies a rounding right shift, saturates to activation width and optionally applies ReLU.
- Emits activations on an ap_fifo output stream toward the next layer.

Parameters:
- NUM_CH, 8: output channels per layer; equals the number of biases streamed per frame.
- NUM_PIX, 16: output pixels per frame; a frame is NUM_PIX*NUM_CH accumulator words.
- ACC_WIDTH, 32: accumulator input width, signed.
- COEFF_WIDTH, 16: bias width, signed; matches the shared coeff_width.
- OUT_WIDTH, 16: activation output width, signed.
- BIAS_SHIFT, 8: left shift aligning the bias to accumulator fixed point.
- OUT_SHIFT, 8: rounding right shift from accumulator to output fixed point; must be at least 1.
- RELU_EN, 1: 1 clamps negative results to 0.

Ports:
- ap_clk  in  1  clock; all logic on the rising edge.
- ap_rst  in  1  synchronous, active-low reset.
- bias_V_dout  in  COEFF_WIDTH  bias word from the bias streamer FIFO.
- bias_V_empty_n  in  1  bias FIFO holds data.
- bias_V_read  out  1  pop one bias word this cycle.
- acc_V_dout  in  ACC_WIDTH  accumulator word, channel-innermost order.
- acc_V_empty_n  in  1  accumulator FIFO holds data.
- acc_V_read  out  1  pop one accumulator word this cycle.
- output_V_din  out  OUT_WIDTH  activation word.
- output_V_full_n  in  1  downstream FIFO has space.
- output_V_write  out  1  push output_V_din this cycle.
- frame_done  out  1  one-cycle pulse when the last word of a frame is written.

Behaviour:
- Reset (ap_rst=0 at a clock edge): state=LOAD, ch_cnt=0, pix_cnt=0, out_valid=0, frame_done=0.
  - All read/write strobes are 0 during reset and in the first cycle after it.
  - The bias register file is not cleared.
  - Reset mid-frame abandons the frame: no further reads or writes until the next LOAD completes.
- LOAD state:
  - bias_V_read = bias_V_empty_n, combinational.
  - Each pop stores bias_V_dout into bias_reg[ch_cnt] and increments ch_cnt.
  - Popping with ch_cnt==NUM_CH-1 sets ch_cnt=0 and moves to RUN.
  - acc_V_read=0 throughout LOAD.
  - The output stage keeps draining: a pending out_valid word may still be written.
- RUN state:
  - advance = acc_V_empty_n && (!out_valid || output_V_full_n).
  - acc_V_read = advance; bias_V_read=0.
  - On advance:
    - sum = sext(acc) + (sext(bias_reg[ch_cnt]) <<< BIAS_SHIFT), computed at ACC_WIDTH+1 bits.
    - r = (sum + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT, arithmetic shift with round-half-up.
    - Saturate r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
    - If RELU_EN, apply max(r,0) after saturation.
    - The result is registered into out_data and out_valid=1.
  - Counters on advance:
    - ch_cnt wraps NUM_CH-1 -> 0 and increments pix_cnt.
    - The word with pix_cnt==NUM_PIX-1 and ch_cnt==NUM_CH-1 is tagged last; state returns to LOAD and pix_cnt=0.
- Output stage:
  - output_V_din = out_data; output_V_write = out_valid && output_V_full_n.
  - On write, out_valid clears unless a new word loads in the same cycle. Simultaneous write and load leaves out_valid=1 with the new data.
  - full_n=0 holds out_data stable; no read occurs while the stage is full.
- Latency: one cycle from acc pop to output_V_write, if full_n=1. Sustained throughput is one word per cycle in RUN.
- frame_done pulses in the cycle the tagged last word is written, not when it is computed.
- LOAD of the next frame may overlap the drain of the last word.

Decomposition:
- Shared package/header: coeff_width, acc/out widths, per-layer NUM_CH/NUM_PIX constants (kern_s_k_*), and the state encoding {LOAD, RUN}.
- One sub-module, bias_round_sat: combinational add, round, saturate and ReLU, parameterised by widths and shifts. Unit-tested standalone.

Test Plan:
- Reset then LOAD with NUM_CH=8, biases 1..8, acc all 0, BIAS_SHIFT=8, OUT_SHIFT=8 -> outputs cycle 1,2,…,8 for 16 pixels; 128 writes; one frame_done on write 128.
- Rounding with bias 0: acc 0x180 -> 2; acc 0x17F -> 1; acc -0x180 -> -1 (round-half-up); with RELU_EN=0 output -1, with RELU_EN=1 output 0.
- Saturation: acc 0x7FFF0000 with bias 0x7FFF -> 0x7FFF; acc 0x80000000 with RELU_EN=0 -> 0x8000.
- Backpressure: hold output_V_full_n=0 for 5 cycles mid-frame -> output_V_din stable, acc_V_read=0, no words lost or duplicated; then one word per cycle resumes.
- Starved inputs:
  - bias_V_empty_n toggles during LOAD -> no acc_V_read until 8 biases are received.
  - acc_V_empty_n gaps in RUN -> channel alignment is preserved (compare against a model).
- Reset asserted at pix_cnt=7, ch_cnt=3 -> strobes low the next cycle; a new frame with fresh biases completes correctly with no stale output word.

Source files
------------

// File: rtl/bias_add_relu_pkg.sv
// Shared widths, per-layer constants and FSM encoding for the bias/round/saturate/ReLU stage.
package bias_add_relu_pkg;

  localparam int COEFF_W          = 16;
  localparam int ACC_W            = 32;
  localparam int OUT_W            = 16;
  localparam int KERN_S_K_NUM_CH  = 8;
  localparam int KERN_S_K_NUM_PIX = 16;
  localparam int KERN_S_K_B_SHIFT = 8;
  localparam int KERN_S_K_O_SHIFT = 8;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Counter width that stays legal for a count of one.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bias_add_relu_if.sv
// ap_fifo bias/accumulator inputs, activation output and frame marker of bias_add_relu.
interface bias_add_relu_if
  import bias_add_relu_pkg::*;
#(
  parameter int COEFF_WIDTH = COEFF_W,
  parameter int ACC_WIDTH   = ACC_W,
  parameter int OUT_WIDTH   = OUT_W
);
  logic [COEFF_WIDTH-1:0] bias_V_dout;
  logic                   bias_V_empty_n;
  logic                   bias_V_read;
  logic [ACC_WIDTH-1:0]   acc_V_dout;
  logic                   acc_V_empty_n;
  logic                   acc_V_read;
  logic [OUT_WIDTH-1:0]   output_V_din;
  logic                   output_V_full_n;
  logic                   output_V_write;
  logic                   frame_done;

  modport master (
    output bias_V_dout, bias_V_empty_n, acc_V_dout, acc_V_empty_n, output_V_full_n,
    input  bias_V_read, acc_V_read, output_V_din, output_V_write, frame_done
  );

  modport slave (
    input  bias_V_dout, bias_V_empty_n, acc_V_dout, acc_V_empty_n, output_V_full_n,
    output bias_V_read, acc_V_read, output_V_din, output_V_write, frame_done
  );
endinterface

// File: rtl/bias_round_sat.sv
// Combinational datapath: accumulator plus aligned bias, round-half-up right shift,
// saturation to the activation range and optional ReLU.
module bias_round_sat #(
  parameter int ACC_WIDTH   = 32,
  parameter int COEFF_WIDTH = 16,
  parameter int OUT_WIDTH   = 16,
  parameter int BIAS_SHIFT  = 8,
  parameter int OUT_SHIFT   = 8,
  parameter bit RELU_EN     = 1'b1
) (
  input  logic signed [ACC_WIDTH-1:0]   acc,
  input  logic signed [COEFF_WIDTH-1:0] bias,
  output logic signed [OUT_WIDTH-1:0]   res
);
  localparam int SW = ACC_WIDTH + 1;
  // One extra bit so the rounding constant cannot wrap a near-full-scale sum.
  localparam int RW = SW + 1;
  localparam logic signed [RW-1:0] HALF = RW'(1) <<< (OUT_SHIFT - 1);
  localparam logic signed [RW-1:0] MAXV = RW'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [RW-1:0] MINV = ~MAXV;

  logic signed [SW-1:0] acc_x;
  logic signed [SW-1:0] bias_x;
  logic signed [SW-1:0] sum;
  logic signed [RW-1:0] rnd;
  logic signed [RW-1:0] shifted;
  logic signed [RW-1:0] sat;

  assign acc_x   = SW'(acc);
  assign bias_x  = SW'(bias) <<< BIAS_SHIFT;
  assign sum     = acc_x + bias_x;
  assign rnd     = RW'(sum) + HALF;
  assign shifted = rnd >>> OUT_SHIFT;

  always_comb begin
    sat = shifted;
    if (shifted > MAXV) begin
      sat = MAXV;
    end else if (shifted < MINV) begin
      sat = MINV;
    end
    if (RELU_EN && sat[RW-1]) begin
      sat = '0;
    end
    res = OUT_WIDTH'(sat);
  end

endmodule

// File: rtl/bias_add_relu.sv
// Loads one bias per output channel, then streams accumulators through the
// bias/round/saturate/ReLU datapath into a single registered output slot.
//
// state | meaning
// LOAD  | popping NUM_CH biases into bias_reg; output slot still drains
// RUN   | one accumulator per cycle while the output slot can accept it
module bias_add_relu
  import bias_add_relu_pkg::*;
#(
  parameter int NUM_CH      = KERN_S_K_NUM_CH,
  parameter int NUM_PIX     = KERN_S_K_NUM_PIX,
  parameter int ACC_WIDTH   = ACC_W,
  parameter int COEFF_WIDTH = COEFF_W,
  parameter int OUT_WIDTH   = OUT_W,
  parameter int BIAS_SHIFT  = KERN_S_K_B_SHIFT,
  parameter int OUT_SHIFT   = KERN_S_K_O_SHIFT,
  parameter bit RELU_EN     = 1'b1
) (
  input  logic           ap_clk,
  input  logic           ap_rst,
  bias_add_relu_if.slave io
);
  localparam int CW = cnt_width(NUM_CH);
  localparam int PW = cnt_width(NUM_PIX);
  localparam logic [CW-1:0] LAST_CH  = CW'(NUM_CH - 1);
  localparam logic [PW-1:0] LAST_PIX = PW'(NUM_PIX - 1);

  state_t                 state, state_nx;
  logic [CW-1:0]          ch_cnt;
  logic [PW-1:0]          pix_cnt;
  logic [COEFF_WIDTH-1:0] bias_reg [NUM_CH];
  logic [OUT_WIDTH-1:0]   out_data;
  logic                   out_valid;
  logic                   out_last;
  logic                   hold_q;
  logic                   go;
  logic                   bias_pop;
  logic                   advance;
  logic                   out_write;
  logic                   frame_end;
  logic [OUT_WIDTH-1:0]   res;

  // Strobes stay quiet while reset is low and for the first cycle after release.
  assign go        = ap_rst && !hold_q;
  assign frame_end = (ch_cnt == LAST_CH) && (pix_cnt == LAST_PIX);
  assign out_write = go && out_valid && io.output_V_full_n;

  always_comb begin
    state_nx = state;
    bias_pop = 1'b0;
    advance  = 1'b0;
    case (state)
      LOAD: begin
        bias_pop = go && io.bias_V_empty_n;
        if (bias_pop && (ch_cnt == LAST_CH)) state_nx = RUN;
      end
      RUN: begin
        advance = go && io.acc_V_empty_n && (!out_valid || io.output_V_full_n);
        if (advance && frame_end) state_nx = LOAD;
      end
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst) begin
      state     <= LOAD;
      ch_cnt    <= '0;
      pix_cnt   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      hold_q    <= 1'b1;
    end else begin
      hold_q <= 1'b0;
      state  <= state_nx;
      if (bias_pop || advance) begin
        ch_cnt <= (ch_cnt == LAST_CH) ? '0 : ch_cnt + 1'b1;
      end
      if (advance && (ch_cnt == LAST_CH)) begin
        pix_cnt <= (pix_cnt == LAST_PIX) ? '0 : pix_cnt + 1'b1;
      end
      if (advance) begin
        out_valid <= 1'b1;
        out_last  <= frame_end;
        out_data  <= res;
      end else if (out_write) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (bias_pop) bias_reg[ch_cnt] <= io.bias_V_dout;
  end

  bias_round_sat #(
    .ACC_WIDTH  (ACC_WIDTH),
    .COEFF_WIDTH(COEFF_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH),
    .BIAS_SHIFT (BIAS_SHIFT),
    .OUT_SHIFT  (OUT_SHIFT),
    .RELU_EN    (RELU_EN)
  ) u_round_sat (
    .acc (io.acc_V_dout),
    .bias(bias_reg[ch_cnt]),
    .res (res)
  );

  assign io.bias_V_read    = bias_pop;
  assign io.acc_V_read     = advance;
  assign io.output_V_din   = out_data;
  assign io.output_V_write = out_write;
  assign io.frame_done     = out_write && out_last;

endmodule

// File: tb/tb_bias_add_relu.sv
// Directed bench: two instances (ReLU on / off) share one stimulus stream; writes are
// scored against hand-computed activations.
module tb_bias_add_relu;
  import bias_add_relu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bias_add_relu_if ifa ();
  bias_add_relu_if ifb ();

  assign ifb.bias_V_dout     = ifa.bias_V_dout;
  assign ifb.bias_V_empty_n  = ifa.bias_V_empty_n;
  assign ifb.acc_V_dout      = ifa.acc_V_dout;
  assign ifb.acc_V_empty_n   = ifa.acc_V_empty_n;
  assign ifb.output_V_full_n = ifa.output_V_full_n;

  bias_add_relu #(.RELU_EN(1'b1)) dut_relu (.ap_clk(clk), .ap_rst(rst), .io(ifa));
  bias_add_relu #(.RELU_EN(1'b0)) dut_lin  (.ap_clk(clk), .ap_rst(rst), .io(ifb));

  logic [15:0] bias_q [$];
  logic [31:0] acc_q  [$];
  logic [15:0] exp_a  [$];
  logic [15:0] exp_b  [$];

  bit rst_v  = 1'b0;
  bit bgate  = 1'b1;
  bit agate  = 1'b1;
  bit full_n = 1'b1;
  bit pop_b  = 1'b0;
  bit pop_a  = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int wr_in_frame = 0;
  int n_fd = 0;
  int first_rd = -1;
  int first_wr = -1;
  int last_fd_cyc = -1;
  logic [15:0] din_hold;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic [15:0] a, input logic [15:0] b);
    exp_a.push_back(a);
    exp_b.push_back(b);
  endtask

  // One clock: apply last cycle's pops, drive inputs at negedge, sample strobes 1ns later.
  task automatic cycle();
    @(negedge clk);
    if (pop_b && bias_q.size() > 0) void'(bias_q.pop_front());
    if (pop_a && acc_q.size() > 0) void'(acc_q.pop_front());
    rst = rst_v;
    ifa.bias_V_empty_n  = bgate && (bias_q.size() > 0);
    ifa.bias_V_dout     = (bias_q.size() > 0) ? bias_q[0] : 16'h0;
    ifa.acc_V_empty_n   = agate && (acc_q.size() > 0);
    ifa.acc_V_dout      = (acc_q.size() > 0) ? acc_q[0] : 32'h0;
    ifa.output_V_full_n = full_n;
    #1;
    cyc++;
    pop_b = ifa.bias_V_read;
    pop_a = ifa.acc_V_read;
    if (pop_a && first_rd < 0) first_rd = cyc;
    if (ifa.output_V_write) begin
      if (first_wr < 0) first_wr = cyc;
      n_cmp++;
      assert (exp_a.size() > 0) else begin
        n_err++;
        $error("FAIL unexpected_write_relu observed=0x%0h expected=no write", ifa.output_V_din);
      end
      if (exp_a.size() > 0) chk("data_relu", ifa.output_V_din, exp_a.pop_front());
      chk("frame_done_on_write", ifa.frame_done, wr_in_frame == 127);
      if (ifa.frame_done) begin
        n_fd++;
        last_fd_cyc = cyc;
      end
      wr_in_frame = (wr_in_frame == 127) ? 0 : wr_in_frame + 1;
    end else begin
      chk("frame_done_idle", ifa.frame_done, 0);
    end
    if (ifb.output_V_write) begin
      n_cmp++;
      assert (exp_b.size() > 0) else begin
        n_err++;
        $error("FAIL unexpected_write_lin observed=0x%0h expected=no write", ifb.output_V_din);
      end
      if (exp_b.size() > 0) chk("data_lin", ifb.output_V_din, exp_b.pop_front());
    end
  endtask

  task automatic drain(input int budget, input bit gaps);
    int k = 0;
    while ((acc_q.size() > 0 || bias_q.size() > 0 || exp_a.size() > 0 || exp_b.size() > 0)
           && k < budget) begin
      if (gaps) agate = (k % 3) != 2;
      cycle();
      k++;
    end
    agate = 1'b1;
    chk("drain_within_budget", acc_q.size() + bias_q.size() + exp_a.size() + exp_b.size(), 0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_bias_read"}, ifa.bias_V_read, 0);
    chk({tag, "_acc_read"}, ifa.acc_V_read, 0);
    chk({tag, "_write"}, ifa.output_V_write, 0);
    chk({tag, "_write_lin"}, ifb.output_V_write, 0);
  endtask

  initial begin
    logic [31:0] accv [8];
    logic [15:0] ea [8];
    logic [15:0] eb [8];

    // Frame 1: biases 1..8, zero accumulators -> outputs 1..8 per pixel.
    for (int c = 0; c < 8; c++) bias_q.push_back(16'(c + 1));
    for (int k = 0; k < 128; k++) begin
      acc_q.push_back(32'h0);
      push_exp(16'((k % 8) + 1), 16'((k % 8) + 1));
    end
    rst_v = 1'b0;
    cycle();
    chk_quiet("in_reset_0");
    chk("in_reset_frame_done", ifa.frame_done, 0);
    cycle();
    chk_quiet("in_reset_1");
    rst_v = 1'b1;
    cycle();
    chk_quiet("first_after_reset");
    cycle();
    chk("load_bias_read", ifa.bias_V_read, 1);
    drain(400, 1'b0);
    chk("f1_frame_done_count", n_fd, 1);
    chk("f1_latency", first_wr - first_rd, 1);
    chk("f1_throughput", last_fd_cyc - first_wr, 127);

    // Frame 2: rounding, saturation and ReLU corners, starved biases, backpressure, gaps.
    accv = '{32'h0000_0180, 32'h0000_017F, 32'hFFFF_FE80, 32'h7FFF_0000,
             32'h8000_0000, 32'h7FFF_0000, 32'h0000_0000, 32'hFFFF_FF80};
    ea   = '{16'h0002, 16'h0001, 16'h0000, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000, 16'h0000};
    eb   = '{16'h0002, 16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h0000};
    for (int c = 0; c < 8; c++) bias_q.push_back((c == 5) ? 16'h7FFF : (c == 6) ? 16'h8000 : 16'h0);
    for (int k = 0; k < 128; k++) begin
      acc_q.push_back(accv[k % 8]);
      push_exp(ea[k % 8], eb[k % 8]);
    end
    for (int i = 0; i < 40 && bias_q.size() > 0; i++) begin
      bgate = i[0];
      cycle();
      if (bias_q.size() > 0) chk("acc_read_during_load", ifa.acc_V_read, 0);
      if (!bgate) chk("bias_read_gated", ifa.bias_V_read, 0);
    end
    bgate = 1'b1;
    chk("f2_biases_loaded", bias_q.size(), 0);
    repeat (40) cycle();
    full_n = 1'b0;
    cycle();
    din_hold = ifa.output_V_din;
    chk("stall_acc_read", ifa.acc_V_read, 0);
    chk("stall_write", ifa.output_V_write, 0);
    for (int i = 1; i < 5; i++) begin
      cycle();
      chk("stall_din_stable", ifa.output_V_din, din_hold);
      chk("stall_acc_read", ifa.acc_V_read, 0);
      chk("stall_write", ifa.output_V_write, 0);
    end
    full_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("resume_write", ifa.output_V_write, 1);
      chk("resume_acc_read", ifa.acc_V_read, 1);
    end
    drain(600, 1'b1);
    chk("f2_frame_done_count", n_fd, 2);

    // Frame 3: abandoned by reset at pix 7 / ch 3 with an unwritten word pending.
    for (int c = 0; c < 8; c++) bias_q.push_back(16'(10 + c));
    for (int k = 0; k < 58; k++) begin
      acc_q.push_back(32'h0);
      push_exp(16'(10 + (k % 8)), 16'(10 + (k % 8)));
    end
    drain(300, 1'b0);
    full_n = 1'b0;
    acc_q.push_back(32'h0);
    for (int c = 0; c < 8; c++) bias_q.push_back(16'(100 + c));
    for (int k = 0; k < 128; k++) acc_q.push_back(32'((k / 8) << 8));
    cycle();
    chk("f3_pop_59", ifa.acc_V_read, 1);
    cycle();
    chk("f3_held_write", ifa.output_V_write, 0);
    chk("f3_held_acc_read", ifa.acc_V_read, 0);
    chk("f3_words_written", exp_a.size(), 0);
    rst_v  = 1'b0;
    full_n = 1'b1;
    cycle();
    chk_quiet("midframe_reset");
    wr_in_frame = 0;
    rst_v = 1'b1;
    cycle();
    chk_quiet("first_after_midframe_reset");

    // Frame 4: fresh biases 100..107, acc = pixel<<8 -> 100 + ch + pixel.
    for (int k = 0; k < 128; k++) push_exp(16'(100 + (k % 8) + (k / 8)), 16'(100 + (k % 8) + (k / 8)));
    cycle();
    chk("f4_load_bias_read", ifa.bias_V_read, 1);
    drain(400, 1'b0);
    chk("f4_frame_done_count", n_fd, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
